// File: rtl/cell_pos_pingpong_buf_if.sv
// rtl/cell_pos_pingpong_buf_if.sv - read, append and bank-swap bus of the ping-pong position store
interface cell_pos_pingpong_buf_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 96
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_start;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_overflow;
    logic                  swap_req;
    logic                  swap_ack;
    logic                  active_bank;
    logic [ADDR_WIDTH-1:0] active_count;

    modport master (
        output rd_en, rd_addr, wr_start, wr_en, wr_data, swap_req,
        input  rd_valid, rd_data, wr_overflow, swap_ack, active_bank, active_count
    );

    modport slave (
        input  rd_en, rd_addr, wr_start, wr_en, wr_data, swap_req,
        output rd_valid, rd_data, wr_overflow, swap_ack, active_bank, active_count
    );
endinterface

// File: rtl/cell_pos_pingpong_buf.sv
// rtl/cell_pos_pingpong_buf.sv - double-buffered per-cell particle position store
// Optional CELL_POS_PARITY_EN adds a stored even-parity bit per word and a sticky parity_err output.
module cell_pos_pingpong_buf #(
    parameter int COMP_WIDTH = 32,
    parameter int DATA_WIDTH = 3 * COMP_WIDTH,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_COUNT = 0
) (
    input  logic clock,
    input  logic rst_n,
    cell_pos_pingpong_buf_if.slave bus
`ifdef CELL_POS_PARITY_EN
    ,
    output logic parity_err
`endif
);

`ifdef CELL_POS_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif
    localparam int                  BANK_WORDS = 2 * DEPTH;
    localparam logic [ADDR_WIDTH:0] PTR_FIRST  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_FULL   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWAP} swap_state_t;

    // Both banks share one array; the bank index is the top address bit.
    logic [WORD_WIDTH-1:0] mem [BANK_WORDS];

    swap_state_t           state;
    logic                  swap_armed;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0] shadow_count;

    logic                  s1_valid;
    logic                  s1_bank;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [ADDR_WIDTH-1:0] s1_count;

    logic                  rd_accept;
    logic [ADDR_WIDTH:0]   ptr_base;
    logic [ADDR_WIDTH-1:0] count_base;
    logic                  wr_store;
    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] rd_word;
    logic                  s1_particle;

    always_comb begin
        rd_accept   = bus.rd_en && (state == S_IDLE);
        // wr_start takes effect before a same-cycle wr_en
        ptr_base    = bus.wr_start ? PTR_FIRST : wr_ptr;
        count_base  = bus.wr_start ? '0 : shadow_count;
        wr_store    = bus.wr_en && (ptr_base != PTR_FULL);
`ifdef CELL_POS_PARITY_EN
        wr_word     = {^bus.wr_data, bus.wr_data};
`else
        wr_word     = bus.wr_data;
`endif
        rd_word     = mem[{s1_bank, s1_addr}];
        s1_particle = (s1_addr != '0) && (s1_addr <= s1_count);
    end

    always_ff @(posedge clock) begin
        if (wr_store) begin
            mem[{~bus.active_bank, ptr_base[ADDR_WIDTH-1:0]}] <= wr_word;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid         <= 1'b0;
            s1_bank          <= 1'b0;
            s1_addr          <= '0;
            s1_count         <= '0;
            bus.rd_valid     <= 1'b0;
            bus.rd_data      <= '0;
            bus.wr_overflow  <= 1'b0;
            bus.swap_ack     <= 1'b0;
            bus.active_bank  <= 1'b0;
            bus.active_count <= ADDR_WIDTH'(INIT_COUNT);
            wr_ptr           <= PTR_FIRST;
            shadow_count     <= '0;
            state            <= S_IDLE;
            swap_armed       <= 1'b0;
`ifdef CELL_POS_PARITY_EN
            parity_err       <= 1'b0;
`endif
        end else begin
            // Bank and count travel with the read so a later swap cannot alter it
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_addr  <= bus.rd_addr;
                s1_bank  <= bus.active_bank;
                s1_count <= bus.active_count;
            end

            bus.rd_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_addr == '0) begin
                    bus.rd_data <= DATA_WIDTH'(s1_count);
                end else if (!s1_particle) begin
                    bus.rd_data <= '0;
                end else begin
                    bus.rd_data <= rd_word[DATA_WIDTH-1:0];
                end
`ifdef CELL_POS_PARITY_EN
                if (s1_particle && (^rd_word)) begin
                    parity_err <= 1'b1;
                end
`endif
            end

            if (bus.wr_start) begin
                bus.wr_overflow <= 1'b0;
            end
            if (bus.wr_en && (ptr_base == PTR_FULL)) begin
                bus.wr_overflow <= 1'b1;
            end
            wr_ptr       <= ptr_base;
            shadow_count <= count_base;
            if (wr_store) begin
                wr_ptr       <= ptr_base + 1'b1;
                shadow_count <= count_base + 1'b1;
            end

            // A held swap_req must drop once before it can trigger another swap
            bus.swap_ack <= 1'b0;
            if (!bus.swap_req) begin
                swap_armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.swap_req && swap_armed) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!s1_valid && !bus.wr_en) begin
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    state            <= S_IDLE;
                    bus.active_bank  <= ~bus.active_bank;
                    bus.active_count <= shadow_count;
                    bus.swap_ack     <= 1'b1;
                    wr_ptr           <= PTR_FIRST;
                    shadow_count     <= '0;
                    swap_armed       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_pos_pingpong_buf.sv
// tb/tb_cell_pos_pingpong_buf.sv - directed self-checking bench for cell_pos_pingpong_buf
module tb_cell_pos_pingpong_buf;
    localparam int AW    = 3;
    localparam int DW    = 96;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    cell_pos_pingpong_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef CELL_POS_PARITY_EN
    logic parity_err;
`endif

    cell_pos_pingpong_buf #(
        .COMP_WIDTH(32),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .INIT_COUNT(0)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef CELL_POS_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_word(input string tag, input int addr, input logic [DW-1:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en   = 1'b0;
        tick();
        check({tag, "_valid"}, DW'(bus.rd_valid), DW'(1));
        check({tag, "_data"}, bus.rd_data, exp);
    endtask

    task automatic do_swap(input bit hold, output int acks);
        acks = 0;
        bus.swap_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.swap_ack) begin
                acks++;
                if (!hold) bus.swap_req = 1'b0;
            end
        end
        bus.swap_req = 1'b0;
        tick();
    endtask

    logic [DW-1:0] burst_exp [3];
    int acks, vcnt, last_v, ack_at, stray_v, stray_ack;

    initial begin
        bus.rd_en = 0; bus.rd_addr = '0; bus.wr_start = 0; bus.wr_en = 0;
        bus.wr_data = '0; bus.swap_req = 0;
        burst_exp[0] = DW'(32'hA); burst_exp[1] = DW'(32'hB); burst_exp[2] = DW'(32'hC);

        // Reset state
        tick(); tick();
        check("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
        check("rst_rd_data", bus.rd_data, DW'(0));
        check("rst_overflow", DW'(bus.wr_overflow), DW'(0));
        check("rst_swap_ack", DW'(bus.swap_ack), DW'(0));
        check("rst_bank", DW'(bus.active_bank), DW'(0));
        check("rst_count", DW'(bus.active_count), DW'(0));
        rst_n = 1'b1;
        tick();

        // Header read latency: nothing after one edge, data after two
        bus.rd_en = 1'b1; bus.rd_addr = '0;
        tick();
        bus.rd_en = 1'b0;
        check("hdr_lat1_valid", DW'(bus.rd_valid), DW'(0));
        tick();
        check("hdr_lat2_valid", DW'(bus.rd_valid), DW'(1));
        check("hdr_data", bus.rd_data, DW'(0));
        tick();
        check("hdr_valid_drop", DW'(bus.rd_valid), DW'(0));

        // Three writes, swap with swap_req held: exactly one ack
        bus.wr_start = 1'b1; tick(); bus.wr_start = 1'b0;
        write_word(DW'(32'hA)); write_word(DW'(32'hB)); write_word(DW'(32'hC));
        do_swap(1'b1, acks);
        check("swap1_acks", DW'(acks), DW'(1));
        check("swap1_bank", DW'(bus.active_bank), DW'(1));
        check("swap1_count", DW'(bus.active_count), DW'(3));
        read_word("rd1", 1, DW'(32'hA));
        read_word("rd2", 2, DW'(32'hB));
        read_word("rd3", 3, DW'(32'hC));
        read_word("rd4_oob", 4, DW'(0));
        read_word("rd_hdr3", 0, DW'(3));

        // Burst reads with swap raised mid-burst
        bus.wr_start = 1'b1; tick(); bus.wr_start = 1'b0;
        write_word(DW'(32'h11)); write_word(DW'(32'h22));
        vcnt = 0; acks = 0; last_v = -1; ack_at = -1;
        for (int i = 0; i < 16; i++) begin
            bus.rd_en   = (i < 6);
            bus.rd_addr = AW'((i % 3) + 1);
            if (i == 2) bus.swap_req = 1'b1;
            tick();
            if (bus.rd_valid) begin
                if (vcnt < 3) check("burst_data", bus.rd_data, burst_exp[vcnt]);
                vcnt++;
                last_v = i;
            end
            if (bus.swap_ack) begin
                acks++;
                ack_at = i;
                bus.swap_req = 1'b0;
            end
        end
        bus.rd_en = 1'b0; bus.swap_req = 1'b0;
        tick();
        check("burst_valids", DW'(vcnt), DW'(3));
        check("burst_acks", DW'(acks), DW'(1));
        check("burst_ack_after_valid", DW'(ack_at > last_v), DW'(1));
        check("burst_bank", DW'(bus.active_bank), DW'(0));
        check("burst_count", DW'(bus.active_count), DW'(2));
        read_word("nb_rd2", 2, DW'(32'h22));
        read_word("nb_rd3_oob", 3, DW'(0));

        // wr_start and wr_en in the same cycle
        bus.wr_start = 1'b1; bus.wr_en = 1'b1; bus.wr_data = DW'(32'h55);
        tick();
        bus.wr_start = 1'b0;
        write_word(DW'(32'h66));
        do_swap(1'b0, acks);
        check("same_cyc_count", DW'(bus.active_count), DW'(2));
        read_word("same_cyc_rd1", 1, DW'(32'h55));
        read_word("same_cyc_rd2", 2, DW'(32'h66));

        // Overflow at DEPTH: 8 writes store 7
        bus.wr_start = 1'b1; tick(); bus.wr_start = 1'b0;
        for (int i = 0; i < 7; i++) write_word(DW'(32'h100 + i));
        check("ovf_before", DW'(bus.wr_overflow), DW'(0));
        write_word(DW'(32'h107));
        check("ovf_set", DW'(bus.wr_overflow), DW'(1));
        do_swap(1'b0, acks);
        check("ovf_count", DW'(bus.active_count), DW'(7));
        check("ovf_sticky", DW'(bus.wr_overflow), DW'(1));
        read_word("ovf_rd7", 7, DW'(32'h106));
        read_word("ovf_hdr", 0, DW'(7));
        bus.wr_start = 1'b1; tick(); bus.wr_start = 1'b0;
        check("ovf_cleared", DW'(bus.wr_overflow), DW'(0));

        // Move to bank 1 so reset has something to undo
        do_swap(1'b0, acks);
        check("pre_rst_bank", DW'(bus.active_bank), DW'(1));

        // Reset with reads in flight and swap draining
        bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
        tick();
        bus.rd_addr = AW'(2); bus.swap_req = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.rd_en = 1'b0; bus.swap_req = 1'b0;
        #1;
        check("rst_mid_valid", DW'(bus.rd_valid), DW'(0));
        tick(); tick();
        rst_n = 1'b1;
        stray_v = 0; stray_ack = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rd_valid) stray_v++;
            if (bus.swap_ack) stray_ack++;
        end
        check("rst_mid_no_valid", DW'(stray_v), DW'(0));
        check("rst_mid_no_ack", DW'(stray_ack), DW'(0));
        check("rst_mid_bank", DW'(bus.active_bank), DW'(0));
        check("rst_mid_count", DW'(bus.active_count), DW'(0));

`ifdef CELL_POS_PARITY_EN
        check("par_rst", DW'(parity_err), DW'(0));
        bus.wr_start = 1'b1; tick(); bus.wr_start = 1'b0;
        write_word(DW'(32'h77));
        do_swap(1'b0, acks);
        dut.mem[9][0] = ~dut.mem[9][0];
        bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
        tick();
        bus.rd_en = 1'b0;
        check("par_before", DW'(parity_err), DW'(0));
        tick();
        check("par_valid", DW'(bus.rd_valid), DW'(1));
        check("par_err", DW'(parity_err), DW'(1));
        tick();
        check("par_sticky", DW'(parity_err), DW'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
